imem_uart_loader: RTL and testbench

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

---
 rtl/imem_uart_loader_pkg.sv | 28 ++
 rtl/loader_timeout_counter.sv | 30 +++
 rtl/imem_uart_loader.sv | 151 +++++++++++++++
 tb/tb_imem_uart_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART boot loader: frame field widths, sync marker
// and the loader state encoding.
package imem_uart_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned CNT_EXT_W = COUNT_W + 1;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Word index to byte address in the fetch PC space.
  function automatic logic [ADDR_W-1:0] word_to_byte_addr(input logic [COUNT_W-1:0] idx);
    return ADDR_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle watchdog between received bytes; expired_c flags the cycle in
// which the idle count reaches TIMEOUT_CYCLES.
module loader_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || clear) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired_c = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/imem_uart_loader.sv
// Receives a framed program image over UART and writes it into instruction
// memory while holding the core in reset.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned       MEM_WORDS      = 256,
  parameter int unsigned       TIMEOUT_CYCLES = 1000000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [CNT_EXT_W-1:0] MEM_WORDS_L = CNT_EXT_W'(MEM_WORDS);

  loader_state_t      state;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] word_index;
  logic [1:0]         byte_idx;
  logic [23:0]        word_lo;
  logic [BYTE_W-1:0]  csum;
  logic               in_frame_c;
  logic               timeout_c;

  assign in_frame_c = (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CSUM);

  loader_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .enable   (in_frame_c),
    .clear    (rx_valid),
    .expired_c(timeout_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      word_index <= '0;
      byte_idx   <= '0;
      word_lo    <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state      <= LEN0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            csum       <= '0;
            word_index <= '0;
            byte_idx   <= '0;
            count      <= '0;
          end
        end

        LEN0: begin
          if (timeout_c) begin
            state      <= ERR;
            load_error <= 1'b1;
          end else if (rx_valid) begin
            count[7:0] <= rx_data;
            state      <= LEN1;
          end
        end

        // Range check uses the full count formed with the incoming high byte.
        LEN1: begin
          if (timeout_c) begin
            state      <= ERR;
            load_error <= 1'b1;
          end else if (rx_valid) begin
            count[15:8] <= rx_data;
            if ({1'b0, rx_data, count[7:0]} > MEM_WORDS_L) begin
              state      <= ERR;
              load_error <= 1'b1;
            end else if ({rx_data, count[7:0]} == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (timeout_c) begin
            state      <= ERR;
            load_error <= 1'b1;
          end else if (rx_valid) begin
            csum     <= csum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              default: begin
                if ({1'b0, word_index} < MEM_WORDS_L) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= word_to_byte_addr(word_index);
                  imem_wdata <= {rx_data, word_lo};
                end
                word_index <= word_index + COUNT_W'(1);
                if (word_index == count - COUNT_W'(1)) begin
                  state <= CSUM;
                end
              end
            endcase
          end
        end

        CSUM: begin
          if (timeout_c) begin
            state      <= ERR;
            load_error <= 1'b1;
          end else if (rx_valid) begin
            if (rx_data == csum) begin
              state     <= DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed frames against the UART loader; a scoreboard monitor checks every
// instruction-memory write against the expected queue.
module tb_imem_uart_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int n_vec = 0;
  int n_err = 0;
  wr_t exp_q[$];
  logic [7:0] frame_q[$];

  always #5 clk = ~clk;

  imem_uart_loader #(
    .MEM_WORDS     (256),
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: pops one expected write per imem_we pulse.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset && imem_we === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (imem_addr !== e.addr || imem_wdata !== e.data) begin
            n_err++;
            $display("FAIL imem_write: got addr %h data %h expected addr %h data %h",
                     imem_addr, imem_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic send_frame();
    foreach (frame_q[i]) begin
      @(negedge clk);
      rx_data  = frame_q[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    frame_q.delete();
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check_status(input string tag, input logic hold, input logic done, input logic err);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
    check({tag, "_load_done"}, 32'(load_done), 32'(done));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, imem_addr, 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Good two-word frame.
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'h0010_0093);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame();
    check_status("good_frame", 1'b0, 1'b1, 1'b0);

    // Same frame, bad checksum: words still written.
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'h0010_0093);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
    send_frame();
    check_status("bad_csum", 1'b1, 1'b0, 1'b1);

    // Count 257 exceeds capacity.
    frame_q = '{8'hA5, 8'h01, 8'h01};
    send_frame();
    #1;
    check("oversize_err_after_len1", 32'(load_error), 32'd1);
    frame_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame();
    check_status("oversize", 1'b1, 1'b0, 1'b1);

    // Stall after 5 payload bytes: timeout 16 cycles after last byte.
    push_wr(32'h0, 32'h0403_0201);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    foreach (frame_q[i]) begin
      @(negedge clk);
      rx_data  = frame_q[i];
      rx_valid = 1'b1;
    end
    frame_q.delete();
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    check("timeout_not_early", 32'(load_error), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (load_error) break;
    end
    n = n + 0;
    check("timeout_cycles", 32'(n), 32'd16);
    check_status("timeout", 1'b1, 1'b0, 1'b1);

    // Reset in the middle of DATA, then a full good frame.
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'h0010_0093);
    frame_q = '{8'hA5, 8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h77};
    send_frame();
    @(negedge clk);
    check("pre_reset_addr", imem_addr, 32'h4);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    push_wr(32'h0, 32'h0000_0013);
    push_wr(32'h4, 32'h0010_0093);
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame();
    check_status("after_reset", 1'b0, 1'b1, 1'b0);

    // Stray bytes ignored; sync byte as payload is plain data.
    push_wr(32'h0, 32'h0000_00A5);
    frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
    send_frame();
    check_status("sync_as_data", 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
